adder_3_bit_sched: RTL and testbench

ADDER_3_BIT_SCHED -- requirements
Module: adder_3_bit_sched

---
 rtl/adder_3_bit_sched.sv | 155 +++++++++++++++
 tb/tb_adder_3_bit_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_3_bit_sched.sv
// adder_3_bit_sched: two requesters share one 3-bit ripple full adder.
// A 6-bit add is performed in two passes (low half, then high half with
// the carry from the low half). Requesters are served round-robin, and
// the result is held until the consumer takes it.
module adder_3_bit_sched #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [5:0] req0_a,
  input  logic [5:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_a,
  input  logic [5:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_sum,
  output logic       rsp_cout,
  output logic       rsp_id
);

  localparam int DATA_W = 6;
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t state, state_nxt;

  // Requester that wins the next tie.
  logic prio_q;

  // Grant decision made in IDLE.
  logic gnt_any;
  logic gnt_id;

  // Captured operation.
  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] opb_p0;
  logic              id_p0;

  // Low-half result.
  logic [HALF_W-1:0] sum_p1;
  logic              carry_p1;

  // Final result.
  logic [DATA_W-1:0] sum_p2;
  logic              cout_p2;

  // Shared adder operands and result {cout, sum}.
  logic [HALF_W-1:0] fa_a;
  logic [HALF_W-1:0] fa_b;
  logic              fa_cin;
  logic [HALF_W:0]   fa_out;

  // Ripple-carry 3-bit full adder: sum = a^b^c, carry = majority(a,b,c).
  function automatic logic [HALF_W:0] add3(input logic [HALF_W-1:0] a,
                                           input logic [HALF_W-1:0] b,
                                           input logic              cin);
    logic [HALF_W-1:0] s;
    logic              c;
    c = cin;
    s = '0;
    for (int i = 0; i < HALF_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // Route the low or high half of the captured operands into the one adder.
  always_comb begin
    fa_a   = '0;
    fa_b   = '0;
    fa_cin = 1'b0;
    if (state == LO) begin
      fa_a = opa_p0[HALF_W-1:0];
      fa_b = opb_p0[HALF_W-1:0];
    end else if (state == HI) begin
      fa_a   = opa_p0[DATA_W-1:HALF_W];
      fa_b   = opb_p0[DATA_W-1:HALF_W];
      fa_cin = carry_p1;
    end
  end

  assign fa_out = add3(fa_a, fa_b, fa_cin);

  // Next-state logic, arbitration and combinational ready.
  always_comb begin
    state_nxt  = state;
    gnt_any    = 1'b0;
    gnt_id     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_any    = 1'b1;
          gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nxt  = LO;
        end
      end
      LO:   state_nxt = HI;
      HI:   state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, tie-break pointer and the low-half carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio_q   <= (FIRST_PRIO != 0);
      carry_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_any) prio_q <= ~gnt_id;
      if (state == LO) carry_p1 <= fa_out[HALF_W];
    end
  end

  // ---- stage p0: capture operands of the granted requester ----
  // Operand capture on accept; later changes on the req ports are ignored.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      opa_p0 <= gnt_id ? req1_a : req0_a;
      opb_p0 <= gnt_id ? req1_b : req0_b;
      id_p0  <= gnt_id;
    end
  end

  // ---- stage p1 / p2: low half, then high half with carry-in ----
  // Collect each half-add result as it leaves the shared adder.
  always_ff @(posedge clk) begin
    if (state == LO) sum_p1 <= fa_out[HALF_W-1:0];
    if (state == HI) begin
      sum_p2  <= {fa_out[HALF_W-1:0], sum_p1};
      cout_p2 <= fa_out[HALF_W];
    end
  end

  // Response is visible only in DONE and reads as zero otherwise.
  always_comb begin
    rsp_valid = (state == DONE);
    rsp_sum   = rsp_valid ? sum_p2 : '0;
    rsp_cout  = rsp_valid ? cout_p2 : 1'b0;
    rsp_id    = rsp_valid ? id_p0 : 1'b0;
  end

endmodule

// File: tb/tb_adder_3_bit_sched.sv
// Testbench for adder_3_bit_sched: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a transaction model.
module tb_adder_3_bit_sched;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [5:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready;
  logic [5:0] rsp_sum;
  logic       rsp_cout, rsp_id;

  adder_3_bit_sched #(.FIRST_PRIO(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction model: idle / busy (counting edges) / holding a response.
  int          m_phase;   // 0 idle, 1 computing, 2 response held
  int          m_cnt;
  logic        m_prio;    // requester that wins the next tie
  logic [31:0] m_res;     // a + b of the in-flight op
  logic [31:0] m_id;

  // Observed values of the latest cycle, and accept flags per requester.
  logic [31:0] o_rv, o_sum, o_cout, o_id, o_r0, o_r1;
  logic        acc0, acc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_prio  = 1'b0;
    m_res   = 0;
    m_id    = 0;
  endtask

  // Called shortly after a falling edge: drive inputs, check the cycle,
  // advance the model across the next rising edge, return after it.
  task automatic cycle(input logic v0, input logic [5:0] a0, input logic [5:0] b0,
                       input logic v1, input logic [5:0] a1, input logic [5:0] b1,
                       input logic rr);
    logic        g_any;
    logic        g_id;
    logic [31:0] ev;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    o_rv = 32'(rsp_valid); o_sum = 32'(rsp_sum); o_cout = 32'(rsp_cout);
    o_id = 32'(rsp_id);    o_r0  = 32'(req0_ready); o_r1 = 32'(req1_ready);
    g_any = (m_phase == 0) && (v0 || v1);
    g_id  = (v0 && v1) ? m_prio : v1;
    ev    = (m_phase == 2) ? 1 : 0;
    chk("rsp_valid", o_rv, ev);
    chk("rsp_sum",   o_sum,  ev != 0 ? (m_res & 63) : 0);
    chk("rsp_cout",  o_cout, ev != 0 ? ((m_res >> 6) & 1) : 0);
    chk("rsp_id",    o_id,   ev != 0 ? m_id : 0);
    chk("req0_ready", o_r0, (g_any && !g_id) ? 1 : 0);
    chk("req1_ready", o_r1, (g_any && g_id) ? 1 : 0);
    chk("ready_excl", o_r0 & o_r1, 0);
    acc0 = g_any && !g_id;
    acc1 = g_any && g_id;
    case (m_phase)
      0: if (g_any) begin
           m_res   = g_id ? (32'(a1) + 32'(b1)) : (32'(a0) + 32'(b0));
           m_id    = 32'(g_id);
           m_prio  = ~g_id;
           m_phase = 1;
           m_cnt   = 2;
         end
      1: if (m_cnt == 1) m_phase = 2; else m_cnt--;
      default: if (rr) m_phase = 0;
    endcase
    @(negedge clk); #1;
  endtask

  task automatic idle_cycle(input logic rr);
    cycle(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, rr);
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release on a falling edge.
  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_sum",   32'(rsp_sum),   0);
    chk("rst_cout",  32'(rsp_cout),  0);
    chk("rst_id",    32'(rsp_id),    0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int prev_k;
    logic [31:0] exp_g;
    int idx;
    logic sel;
    int budget;
    logic [5:0] ra, rb;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 45 + 27 = 72: carry out of the low half and out of the top.
    cycle(1'b1, 6'd45, 6'd27, 1'b0, 6'd0, 6'd0, 1'b1);
    chk("t25_ready", o_r0, 1);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    chk("t25_valid", o_rv, 1);
    chk("t25_sum",   o_sum, 8);
    chk("t25_cout",  o_cout, 1);
    chk("t25_id",    o_id, 0);

    // Both requesters always valid: grants alternate starting with 0.
    do_reset();
    exp_g = 0; prev_k = -1;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 6'($urandom), 6'($urandom), 1'b1, 6'($urandom), 6'($urandom), 1'b1);
      if (o_r0[0] || o_r1[0]) begin
        chk("t26_grant", o_r1, exp_g);
        if (prev_k >= 0) chk("t26_gap", 32'(k - prev_k), 4);
        prev_k = k;
        exp_g  = exp_g ^ 1;
      end
      if (o_rv[0]) chk("t26_rspid", o_id, exp_g ^ 1);
    end
    chk("t26_count", 32'(prev_k), 12);

    // 63 + 63 held while the consumer stalls.
    do_reset();
    cycle(1'b0, 6'd0, 6'd0, 1'b1, 6'd63, 6'd63, 1'b0);
    chk("t27_ready", o_r1, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'd1, 6'd2, 1'b1, 6'd3, 6'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 6'd1, 6'd2, 1'b1, 6'd3, 6'd4, 1'b0);
      chk("t27_valid", o_rv, 1);
      chk("t27_sum",   o_sum, 62);
      chk("t27_cout",  o_cout, 1);
      chk("t27_id",    o_id, 1);
      chk("t27_noacc", o_r0 | o_r1, 0);
    end
    cycle(1'b1, 6'd1, 6'd2, 1'b1, 6'd3, 6'd4, 1'b1);
    chk("t27_noacc_consume", o_r0 | o_r1, 0);
    cycle(1'b1, 6'd1, 6'd2, 1'b1, 6'd3, 6'd4, 1'b1);
    chk("t27_resume", o_r0, 1);

    // Reset while the high half is being computed aborts the op.
    do_reset();
    cycle(1'b1, 6'd7, 6'd1, 1'b0, 6'd0, 6'd0, 1'b1);
    idle_cycle(1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_cycle(1'b1);
      chk("t28_noresp", o_rv, 0);
    end
    cycle(1'b1, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1);
    chk("t28_ready", o_r0, 1);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    chk("t28_valid", o_rv, 1);
    chk("t28_sum",   o_sum, 0);
    chk("t28_cout",  o_cout, 0);

    // Accept first reset edge directly, then scramble operands in flight.
    do_reset();
    cycle(1'b1, 6'd10, 6'd20, 1'b0, 6'd0, 6'd0, 1'b0);
    chk("t29_ready", o_r0, 1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 6'($urandom), 6'($urandom), 1'b0, 6'd0, 6'd0, 1'b0);
    chk("t29_sum",  o_sum, 30);
    chk("t29_cout", o_cout, 0);
    chk("t29_valid", o_rv, 1);

    // Exhaustive a/b sweep, each pair on a random port, with cross traffic.
    do_reset();
    idx = 0; sel = 1'($urandom); budget = 60000;
    while (idx < 4096 && budget > 0) begin
      ra = 6'(idx >> 6); rb = 6'(idx & 63);
      if (sel == 1'b0)
        cycle(1'b1, ra, rb, ($urandom_range(3) == 0), 6'($urandom), 6'($urandom),
              ($urandom_range(3) != 0));
      else
        cycle(($urandom_range(3) == 0), 6'($urandom), 6'($urandom), 1'b1, ra, rb,
              ($urandom_range(3) != 0));
      if ((sel == 1'b0 && acc0) || (sel == 1'b1 && acc1)) begin
        idx++;
        sel = 1'($urandom);
      end
      budget--;
    end
    chk("sweep_done", 32'(idx), 4096);

    // Fully random traffic with occasional resets in any state.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(149) == 0) do_reset();
      cycle(1'($urandom), 6'($urandom), 6'($urandom),
            1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
